// File: rtl/bidir_bus_pkg.sv
// Shared types and default parameters for the half-duplex bus controller.
package bidir_bus_pkg;

  localparam int BUS_N_DEF = 8;
  localparam int DEAD_DEF  = 2;
  localparam int HOLD_DEF  = 2;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    GUARD_ON  = 2'd1,
    DRIVE     = 2'd2,
    GUARD_OFF = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_tristate.sv
// Tristate driver for the shared bus plus the readback of whatever is on it.
module bus_tristate #(
  parameter int N = 8
) (
  input  logic         en,
  input  logic [N-1:0] dout,
  output logic [N-1:0] din,
  inout  wire  [N-1:0] bus
);

  assign bus = en ? dout : {N{1'bz}};
  assign din = bus;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// One end of a half-duplex tristate bus with break-before-make guard windows.
// Define BIDIR_CONTENTION_CHECK_EN to enable the sticky overlap detector and forced DRIVE exit.
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int N    = BUS_N_DEF,
  parameter int DEAD = DEAD_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic         peer_oe,
  output logic         oe,
  inout  wire  [N-1:0] bi_data,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         busy,
  output logic         contention
);

  localparam int CNT_W = $clog2(max_int(DEAD, HOLD) + 1);
  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [N-1:0]     word_q, word_d;
  logic             oe_q, oe_d;
  logic             active_q, active_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic             peer_prev_q, peer_prev_d;
  logic [N-1:0]     rx_q, rx_d;
  logic             contention_q, contention_d;
  logic             force_exit;
  logic             rx_fall;
  logic [N-1:0]     bus_in;

  bus_tristate #(.N(N)) u_tristate (
    .en   (oe_q),
    .dout (word_q),
    .din  (bus_in),
    .bus  (bi_data)
  );

`ifdef BIDIR_CONTENTION_CHECK_EN
  assign force_exit   = oe_q & peer_oe;
  assign contention_d = contention_q | (oe_q & peer_oe);
`else
  assign force_exit   = 1'b0;
  assign contention_d = 1'b0;
`endif

  // active_q holds tx_ready low until the first edge after reset release.
  assign tx_ready = active_q & (state_q == IDLE) & ~pending_q & ~peer_oe;
  assign busy     = (state_q != IDLE) | pending_q;
  assign active_d = 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    word_d    = word_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          word_d    = tx_data;
          pending_d = 1'b1;
          state_d   = GUARD_ON;
          cnt_d     = DEAD_LD;
        end else if (pending_q && !peer_oe) begin
          state_d = GUARD_ON;
          cnt_d   = DEAD_LD;
        end
      end
      GUARD_ON: begin
        // A peer taking the bus wins; the word stays pending for a retry.
        if (peer_oe) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == '0 || force_exit) begin
          state_d   = GUARD_OFF;
          cnt_d     = DEAD_LD;
          pending_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GUARD_OFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    oe_d = (state_d == DRIVE);
  end

  // The capture is presented in the very cycle the peer's enable is seen low.
  always_comb begin
    shadow_d    = (peer_oe && !oe_q) ? bus_in : shadow_q;
    peer_prev_d = peer_oe;
    rx_fall     = peer_prev_q & ~peer_oe;
    rx_d        = rx_fall ? shadow_q : rx_q;
  end

  assign rx_data    = rx_d;
  assign rx_valid   = rx_fall;
  assign oe         = oe_q;
  assign contention = contention_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      word_q       <= '0;
      oe_q         <= 1'b0;
      active_q     <= 1'b0;
      shadow_q     <= '0;
      peer_prev_q  <= 1'b0;
      rx_q         <= '0;
      contention_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      word_q       <= word_d;
      oe_q         <= oe_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      peer_prev_q  <= peer_prev_d;
      rx_q         <= rx_d;
      contention_q <= contention_d;
    end
  end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Two cross-connected bidir_bus_ctrl instances with a scoreboard on each receive path.
module tb_bidir_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_tx_data = '0, b_tx_data = '0;
  logic       a_tx_valid = 1'b0, b_tx_valid = 1'b0;
  logic       force_peer = 1'b0;
  logic       a_tx_ready, b_tx_ready, a_oe, b_oe;
  logic       a_rx_valid, b_rx_valid, a_busy, b_busy;
  logic       a_contention, b_contention;
  logic [7:0] a_rx_data, b_rx_data;
  logic       a_peer_oe;
  wire  [7:0] bus;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  assign a_peer_oe = b_oe | force_peer;

  // Weak pull-ups make a released bus read back as 0xFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bus[i]);
  end

  always #5 clk = ~clk;

  bidir_bus_ctrl #(.N(8), .DEAD(2), .HOLD(2)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .peer_oe(a_peer_oe), .oe(a_oe), .bi_data(bus),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy),
    .contention(a_contention)
  );

  bidir_bus_ctrl #(.N(8), .DEAD(2), .HOLD(2)) u_b (
    .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .peer_oe(a_oe), .oe(b_oe), .bi_data(bus),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy),
    .contention(b_contention)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Presents a word on one side and returns at the negedge of the first cycle after acceptance.
  task automatic applyStimulus(input bit to_b, input logic [7:0] data);
    int budget;
    budget = 50;
    if (to_b) begin
      b_tx_data = data; b_tx_valid = 1'b1;
    end else begin
      a_tx_data = data; a_tx_valid = 1'b1;
    end
    while (!(to_b ? b_tx_ready : a_tx_ready) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput(to_b ? "b_accept_wait" : "a_accept_wait", 32'(budget > 0), 32'd1);
    @(negedge clk);
    if (to_b) b_tx_valid = 1'b0;
    else      a_tx_valid = 1'b0;
  endtask

  // Bit k-1 of each pattern is the expected value in cycle k, starting from the current negedge.
  task automatic checkWindow(input string tag, input int n,
                             input logic [15:0] a_oe_p, input logic [15:0] b_oe_p,
                             input logic [15:0] a_rxv_p, input logic [15:0] b_rxv_p,
                             input logic [15:0] a_rdy_p);
    logic acc;
    for (int k = 1; k <= n; k++) begin
      acc = a_tx_valid & a_tx_ready;
      checkOutput($sformatf("%s_a_oe_c%0d", tag, k), 32'(a_oe), 32'(a_oe_p[k-1]));
      checkOutput($sformatf("%s_b_oe_c%0d", tag, k), 32'(b_oe), 32'(b_oe_p[k-1]));
      checkOutput($sformatf("%s_a_rxv_c%0d", tag, k), 32'(a_rx_valid), 32'(a_rxv_p[k-1]));
      checkOutput($sformatf("%s_b_rxv_c%0d", tag, k), 32'(b_rx_valid), 32'(b_rxv_p[k-1]));
      checkOutput($sformatf("%s_a_rdy_c%0d", tag, k), 32'(a_tx_ready), 32'(a_rdy_p[k-1]));
      if (k < n) begin
        @(negedge clk);
        if (acc) a_tx_valid = 1'b0;
      end
    end
  endtask

  // Scoreboard monitor: pops an expected word for every rx_valid pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (a_oe && b_oe) overlap++;
      if (a_rx_valid) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL a_rx_unexpected: got %0h, expected no capture", a_rx_data);
        end else begin
          checkOutput("a_rx_data", 32'(a_rx_data), 32'(exp_a.pop_front()));
        end
      end
      if (b_rx_valid) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL b_rx_unexpected: got %0h, expected no capture", b_rx_data);
        end else begin
          checkOutput("b_rx_data", 32'(b_rx_data), 32'(exp_b.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit cc_en;
`ifdef BIDIR_CONTENTION_CHECK_EN
    cc_en = 1'b1;
`else
    cc_en = 1'b0;
`endif
    // Reset values while rst is held.
    @(negedge clk);
    checkOutput("rst_a_oe", 32'(a_oe), 32'd0);
    checkOutput("rst_a_ready", 32'(a_tx_ready), 32'd0);
    checkOutput("rst_b_ready", 32'(b_tx_ready), 32'd0);
    checkOutput("rst_a_rx_data", 32'(a_rx_data), 32'd0);
    checkOutput("rst_a_rx_valid", 32'(a_rx_valid), 32'd0);
    checkOutput("rst_a_busy", 32'(a_busy), 32'd0);
    checkOutput("rst_a_contention", 32'(a_contention), 32'd0);
    checkOutput("rst_bus", 32'(bus), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rel_a_ready", 32'(a_tx_ready), 32'd1);
    checkOutput("rel_b_ready", 32'(b_tx_ready), 32'd1);
    checkOutput("rel_a_busy", 32'(a_busy), 32'd0);
    checkOutput("rel_bus", 32'(bus), 32'hFF);

    $display("[TB] A sends 0xA5");
    exp_b.push_back(8'hA5);
    applyStimulus(1'b0, 8'hA5);
    checkWindow("single", 7, 16'h000C, 16'h0000, 16'h0000, 16'h0010, 16'h0040);

    $display("[TB] B takes the bus while A is in its guard window");
    exp_a.push_back(8'h3C);
    exp_b.push_back(8'h5A);
    applyStimulus(1'b1, 8'h3C);
    a_tx_data = 8'h5A; a_tx_valid = 1'b1;
    checkWindow("yield", 12, 16'h0180, 16'h000C, 16'h0010, 16'h0200, 16'h0801);

    $display("[TB] back-to-back words from A");
    exp_b.push_back(8'h01);
    exp_b.push_back(8'h02);
    applyStimulus(1'b0, 8'h01);
    a_tx_data = 8'h02; a_tx_valid = 1'b1;
    checkWindow("b2b", 14, 16'h060C, 16'h0000, 16'h0000, 16'h0810, 16'h2040);

    $display("[TB] reset during A drive window");
    applyStimulus(1'b0, 8'h77);
    @(negedge clk);
    @(negedge clk);
    checkOutput("drv_a_oe", 32'(a_oe), 32'd1);
    checkOutput("drv_bus", 32'(bus), 32'h77);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_a_oe", 32'(a_oe), 32'd0);
    checkOutput("async_bus", 32'(bus), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_a_ready", 32'(a_tx_ready), 32'd1);
    checkOutput("post_rst_a_busy", 32'(a_busy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("post_rst_b_rxv_%0d", k), 32'(b_rx_valid), 32'd0);
      checkOutput($sformatf("post_rst_a_oe_%0d", k), 32'(a_oe), 32'd0);
      @(negedge clk);
    end

    $display("[TB] peer enable forced during A drive window");
    exp_a.push_back(8'h00);
    exp_b.push_back(8'h99);
    applyStimulus(1'b0, 8'h99);
    @(negedge clk);
    @(negedge clk);
    checkOutput("cc_a_oe_c3", 32'(a_oe), 32'd1);
    force_peer = 1'b1;
    @(posedge clk);
    #1 force_peer = 1'b0;
    @(negedge clk);
    checkOutput("cc_a_oe_c4", 32'(a_oe), 32'(!cc_en));
    checkOutput("cc_contention_c4", 32'(a_contention), 32'(cc_en));
    checkOutput("cc_b_rxv_c4", 32'(b_rx_valid), 32'(cc_en));
    checkOutput("cc_a_rxv_c4", 32'(a_rx_valid), 32'd1);
    @(negedge clk);
    checkOutput("cc_a_oe_c5", 32'(a_oe), 32'd0);
    checkOutput("cc_b_rxv_c5", 32'(b_rx_valid), 32'(!cc_en));
    @(negedge clk);
    checkOutput("cc_a_rdy_c6", 32'(a_tx_ready), 32'(cc_en));
    @(negedge clk);
    checkOutput("cc_a_rdy_c7", 32'(a_tx_ready), 32'd1);
    checkOutput("cc_contention_sticky", 32'(a_contention), 32'(cc_en));
    checkOutput("cc_b_contention", 32'(b_contention), 32'd0);

    repeat (4) @(negedge clk);
    checkOutput("exp_a_drained", 32'(exp_a.size()), 32'd0);
    checkOutput("exp_b_drained", 32'(exp_b.size()), 32'd0);
    checkOutput("no_oe_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bidir_bus_ctrl.md
# bidir_bus_ctrl

Half-duplex controller for one end of a shared N-bit tristate bus. It accepts words over a valid/ready handshake and drives them onto `bi_data` with break-before-make guard time around its output enable. It also captures words driven by the peer end, framed by the peer's enable. One instance sits at each end of the bus, and each instance's `oe` feeds the other's `peer_oe`.

## Interface
- `N`, 8, bus and data width.
- `DEAD`, 2, guard cycles with `oe` low before and after each drive window; must be ≥1.
- `HOLD`, 2, cycles `oe` is held high per word; must be ≥1.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  N  word to transmit.
- `tx_valid`  in  1  transmit request.
- `tx_ready`  out  1  word accepted on the edge where `tx_valid & tx_ready`.
- `peer_oe`  in  1  far end's output enable, synchronous to `clk`.
- `oe`  out  1  this end's output enable (registered).
- `bi_data`  inout  N  shared bus; driven with the latched word when `oe` is high, else `'z`.
- `rx_data`  out  N  last word captured from the peer.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  high in any state other than IDLE, or while a word is pending.
- `contention`  out  1  sticky overlap flag (see Configuration).

## Operation
- FSM states: IDLE, GUARD_ON, DRIVE, GUARD_OFF.
- IDLE:
  - `tx_ready = ~peer_oe & ~pending`.
  - On accept: latch `tx_data`, set `pending`, go to GUARD_ON.
- GUARD_ON:
  - Counts DEAD cycles with `oe=0`, then goes to DRIVE.
  - If `peer_oe` is sampled high: return to IDLE and keep `pending` and the latched word.
  - When IDLE sees `pending & ~peer_oe`, it re-enters GUARD_ON automatically.
- DRIVE:
  - `oe=1` and the bus carries the latched word for HOLD cycles.
  - Clears `pending`, then goes to GUARD_OFF.
- GUARD_OFF: DEAD cycles with `oe=0`, then IDLE.
- Receive path:
  - Every cycle with `peer_oe=1` and `oe=0`, the bus is sampled into a shadow register.
  - On the first cycle `peer_oe` is sampled low after a high, `rx_data <= shadow` and `rx_valid` pulses.
  - `rx_data` holds its value until the next capture.
- Simultaneous peer fall and local accept: the receive capture still occurs, and the transmit proceeds normally.
- Guard and hold counters are `$clog2(max(DEAD,HOLD)+1)` bits wide. They count down and load on state entry; there is no wrap.

## Timing
- Reset values, while `rst` is high:
  - `oe=0`, `bi_data='z`, `tx_ready=0`, `rx_data=0`, `rx_valid=0`, `busy=0`, `contention=0`.
  - State IDLE and `pending=0`.
  - The first cycle after release: `tx_ready=~peer_oe`.
- Accept on edge T:
  - GUARD_ON in cycles T+1..T+DEAD.
  - `oe` high in cycles T+DEAD+1..T+DEAD+HOLD.
  - IDLE again at T+2·DEAD+HOLD+1.
  - With defaults: `oe` is high in cycles 3–4 and `tx_ready` returns in cycle 7.
- `rx_valid` occurs exactly 1 cycle after the peer's last high cycle.
- `rst` asserted mid-DRIVE: `oe` drops and the bus releases asynchronously. The pending word is discarded.

## Configuration
- `BIDIR_CONTENTION_CHECK_EN` defined:
  - If `oe & peer_oe` is sampled on any edge, `contention` sets and stays set until `rst`.
  - The FSM is forced from DRIVE to GUARD_OFF on the next edge, and the word counts as sent.
- `BIDIR_CONTENTION_CHECK_EN` undefined:
  - `contention` is tied to 0.
  - No forced exit; DRIVE always completes HOLD cycles.

## Structure
- Package `bidir_bus_pkg` holds:
  - The state enum (IDLE, GUARD_ON, DRIVE, GUARD_OFF).
  - Its width constant.
  - The default `N`, `DEAD` and `HOLD` constants.
- One sub-module, `bus_tristate #(N)`, contains the `bi_data` driver with enable and the readback wire. Everything else lives in `bidir_bus_ctrl`.

## Test plan
Two instances are cross-connected (`oe`↔`peer_oe`) with defaults N=8, DEAD=2, HOLD=2.
- Reset release with idle peer → `tx_ready=1` on cycle 1, all other outputs at reset values, bus `'z`.
- A sends 0xA5 → A `oe` high in cycles 3–4 only. B `rx_data=0xA5`, with `rx_valid` pulsed once in cycle 5. A `tx_ready` returns in cycle 7.
- B begins driving 0x3C while A is in GUARD_ON → A returns to IDLE, B completes, B's 0x3C is captured by A, and then A automatically resends its pending word. Both `oe` outputs are never high together.
- Back-to-back `tx_valid` with 0x01, then 0x02 → two drive windows, each preceded and followed by 2 guard cycles. B captures 0x01, then 0x02.
- `rst` pulsed during A's DRIVE → A's `oe` falls within the same cycle, the bus goes `'z`, and B sees no `rx_valid`.
- With the macro defined, force `peer_oe=1` during DRIVE → `contention=1` (sticky) and the FSM reaches GUARD_OFF next cycle. Without the macro, `contention` stays 0 and DRIVE lasts 2 cycles.
